// File: rtl/rf_seq_pkg.sv
// Shared types and defaults for the register-file ALU sequencer.
// Holds the opcode and FSM state encodings and the default datapath sizes.
package rf_seq_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_MOV = 3'd5,
        OP_SLL = 3'd6,
        OP_NOP = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CAPT  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // NOP is the only opcode that retires without touching the register file.
    function automatic logic op_writes(input op_e op);
        return op != OP_NOP;
    endfunction

endpackage

// File: rtl/rf_alu_sequencer_if.sv
// Command-side bundle of the sequencer: instruction handshake plus retire/result.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; the source holds all cmd_* fields stable while cmd_valid is high and not yet accepted.
interface rf_alu_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rd;
    logic [ADDR_W-1:0] cmd_rs1;
    logic [ADDR_W-1:0] cmd_rs2;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
        input  cmd_ready, done, result
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
        output cmd_ready, done, result
    );
endinterface

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer: y = op(a, b), modulo 2^DATA_W, no flags.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  op_e               i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y
);
    localparam int SH_W = $clog2(DATA_W);

    always_comb begin
        o_y = '0;
        case (i_op)
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_MOV:  o_y = i_a;
            // Only the low bits of b form the shift amount.
            OP_SLL:  o_y = i_a << i_b[SH_W-1:0];
            OP_NOP:  o_y = '0;
            default: o_y = '0;
        endcase
    end
endmodule

// File: rtl/rf_alu_sequencer.sv
// Register-to-register ALU sequencer: read rs1/rs2 on RF read ports 1/2,
// capture and compute, then write the result to rd through RF write port 1.
module rf_alu_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    rf_alu_sequencer_if.slave cmd_if,
    output logic              r1,
    output logic              r2,
    output logic [ADDR_W-1:0] r1p,
    output logic [ADDR_W-1:0] r2p,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic              w1,
    output logic [ADDR_W-1:0] w1p,
    output logic [DATA_W-1:0] ip1,
    output state_e            dbg_state
);
    state_e            r_state;
    op_e               r_op;
    logic [ADDR_W-1:0] r_rd;
    logic              r_r1;
    logic              r_r2;
    logic [ADDR_W-1:0] r_r1p;
    logic [ADDR_W-1:0] r_r2p;
    logic              r_w1;
    logic [ADDR_W-1:0] r_w1p;
    logic [DATA_W-1:0] r_ip1;
    logic [DATA_W-1:0] r_result;
    logic              r_done;

    logic              w_accept;
    logic [DATA_W-1:0] w_alu_y;

    rf_seq_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op (r_op),
        .i_a  (op1),
        .i_b  (op2),
        .o_y  (w_alu_y)
    );

    assign cmd_if.cmd_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept         = cmd_if.cmd_valid && cmd_if.cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_NOP;
            r_rd     <= '0;
            r_r1     <= 1'b0;
            r_r2     <= 1'b0;
            r_r1p    <= '0;
            r_r2p    <= '0;
            r_w1     <= 1'b0;
            r_w1p    <= '0;
            r_ip1    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= op_e'(cmd_if.cmd_op);
                        r_rd    <= cmd_if.cmd_rd;
                        r_r1    <= 1'b1;
                        r_r2    <= 1'b1;
                        r_r1p   <= cmd_if.cmd_rs1;
                        r_r2p   <= cmd_if.cmd_rs2;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    // The register file loads op1/op2 on this edge.
                    r_r1    <= 1'b0;
                    r_r2    <= 1'b0;
                    r_state <= ST_CAPT;
                end
                ST_CAPT: begin
                    r_result <= w_alu_y;
                    r_ip1    <= w_alu_y;
                    r_w1     <= op_writes(r_op);
                    r_w1p    <= r_rd;
                    r_state  <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_w1    <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign r1  = r_r1;
    assign r2  = r_r2;
    assign r1p = r_r1p;
    assign r2p = r_r2p;
    // A reset sampled on the WRITE edge must also keep the register file from committing.
    assign w1  = r_w1 && !reset;
    assign w1p = r_w1p;
    assign ip1 = r_ip1;

    assign cmd_if.done   = r_done;
    assign cmd_if.result = r_result;
    assign dbg_state     = r_state;
endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Closed-loop bench: sequencer driving a behavioural 4R/2W register file model.
module tb_rf_alu_sequencer;
    import rf_seq_pkg::*;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int QW = AW + DW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rf_alu_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) cmd_if ();

    logic          r1, r2, w1;
    logic [AW-1:0] r1p, r2p, w1p;
    logic [DW-1:0] op1, op2, ip1;
    state_e        dbg_state;

    rf_alu_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_if    (cmd_if),
        .r1        (r1),
        .r2        (r2),
        .r1p       (r1p),
        .r2p       (r2p),
        .op1       (op1),
        .op2       (op2),
        .w1        (w1),
        .w1p       (w1p),
        .ip1       (ip1),
        .dbg_state (dbg_state)
    );

    // Register file model: registered reads, write port 1 blocks reads on ports 1/2.
    logic          r3 = 1'b0;
    logic [AW-1:0] r3p = '0;
    logic [DW-1:0] op3;
    logic          w2 = 1'b0;
    logic [AW-1:0] w2p = '0;
    logic [DW-1:0] ip2 = '0;
    logic [DW-1:0] mem [32];

    always @(posedge clk) begin
        if (r1 && !w1) op1 <= mem[r1p];
        if (r2 && !w1) op2 <= mem[r2p];
        if (r3) op3 <= mem[r3p];
        if (w2) mem[w2p] <= ip2;
        if (w1) mem[w1p] <= ip1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_done_exp = 0;
    int n_acc = 0;
    int n_acc_exp = 0;
    logic [QW-1:0] exp_q[$];
    logic [QW-1:0] mon_e;
    logic [DW-1:0] model [32];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%h exp=0x%h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a;
            3'd6:    return a << b[5:0];
            default: return 64'd0;
        endcase
    endfunction

    // Scoreboard: every write-port-1 pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset) begin
            check("rw_overlap", 64'((r1 | r2) & w1), 64'd0);
            if (w1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_w1", 64'(w1p), 64'h0bad);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("w1p", 64'(w1p), 64'(mon_e[QW-1:DW]));
                    check("ip1", ip1, mon_e[DW-1:0]);
                    check("result", cmd_if.result, mon_e[DW-1:0]);
                end
            end
            if (cmd_if.done) n_done++;
        end
    end

    always @(posedge clk) begin
        if (!reset && cmd_if.cmd_valid && cmd_if.cmd_ready) n_acc++;
    end

    task automatic rf_write2(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        w2 = 1'b1; w2p = a; ip2 = d;
        @(posedge clk); #1;
        w2 = 1'b0;
        model[a] = d;
    endtask

    task automatic rf_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        @(negedge clk);
        r3 = 1'b1; r3p = a;
        @(posedge clk); #1;
        r3 = 1'b0;
        d = op3;
    endtask

    task automatic wait_idle();
        repeat (6) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                            input logic [AW-1:0] rs2, input bit retire, output int acc_cyc);
        int waited;
        logic [DW-1:0] val;
        waited = 0;
        acc_cyc = -1;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op = op; cmd_if.cmd_rd = rd; cmd_if.cmd_rs1 = rs1; cmd_if.cmd_rs2 = rs2;
        while (!cmd_if.cmd_ready) begin
            waited++;
            if (waited > 20) begin
                check("accept_timeout", 64'(waited), 64'd0);
                cmd_if.cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        cmd_if.cmd_valid = 1'b0;
        n_acc_exp++;
        if (retire) begin
            n_done_exp++;
            if (op != 3'd7) begin
                val = ref_alu(op, model[rs1], model[rs2]);
                exp_q.push_back({rd, val});
                model[rd] = val;
            end
        end
    endtask

    initial begin
        int a0, a1;
        logic [DW-1:0] rd_val;
        int nd;

        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            model[i] = '0;
        end
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op = '0; cmd_if.cmd_rd = '0; cmd_if.cmd_rs1 = '0; cmd_if.cmd_rs2 = '0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_hi", 64'(cmd_if.cmd_ready), 64'd0);
        check("rst_r1", 64'(r1 | r2), 64'd0);
        check("rst_w1", 64'(w1), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rel_ready", 64'(cmd_if.cmd_ready), 64'd1);
        check("rel_state", 64'(dbg_state), 64'(ST_IDLE));
        check("rel_addrs", 64'({r1p, r2p, w1p}), 64'd0);
        check("rel_ip1", ip1, 64'd0);
        check("rel_result", cmd_if.result, 64'd0);
        check("rel_done", 64'(cmd_if.done), 64'd0);

        for (int i = 0; i < 32; i++) rf_write2(5'(i), {$urandom, $urandom});
        rf_write2(5'd1, 64'd100);
        rf_write2(5'd2, 64'd200);
        rf_write2(5'd7, 64'd4);

        // ADD R3 = R1 + R2 with cycle-by-cycle timing
        send_cmd(3'd0, 5'd3, 5'd1, 5'd2, 1'b1, a0);
        @(negedge clk);
        check("c1_reads", 64'({r1, r2, w1}), 64'b110);
        check("c1_addrs", 64'({r1p, r2p}), 64'({5'd1, 5'd2}));
        check("c1_ready", 64'(cmd_if.cmd_ready), 64'd0);
        check("c1_state", 64'(dbg_state), 64'(ST_READ));
        @(negedge clk);
        check("c2_enables", 64'({r1, r2, w1}), 64'd0);
        check("c2_ready", 64'(cmd_if.cmd_ready), 64'd0);
        @(negedge clk);
        check("c3_w1", 64'(w1), 64'd1);
        check("c3_w1p", 64'(w1p), 64'd3);
        check("c3_ip1", ip1, 64'd300);
        check("c3_ready", 64'(cmd_if.cmd_ready), 64'd0);
        @(negedge clk);
        check("c4_done", 64'(cmd_if.done), 64'd1);
        check("c4_ready", 64'(cmd_if.cmd_ready), 64'd1);
        @(negedge clk);
        check("c5_done", 64'(cmd_if.done), 64'd0);
        rf_read(5'd3, rd_val);
        check("rd_R3", rd_val, 64'd300);

        send_cmd(3'd1, 5'd4, 5'd1, 5'd2, 1'b1, a0);
        send_cmd(3'd6, 5'd8, 5'd1, 5'd7, 1'b1, a0);
        send_cmd(3'd4, 5'd9, 5'd1, 5'd1, 1'b1, a0);
        send_cmd(3'd0, 5'd0, 5'd1, 5'd1, 1'b1, a0);
        wait_idle();
        rf_read(5'd4, rd_val);
        check("rd_R4_sub", rd_val, 64'hFFFF_FFFF_FFFF_FF9C);
        rf_read(5'd8, rd_val);
        check("rd_R8_sll", rd_val, 64'd1600);
        rf_read(5'd9, rd_val);
        check("rd_R9_xor", rd_val, 64'd0);
        rf_read(5'd0, rd_val);
        check("rd_R0_add", rd_val, 64'd200);

        // RAW chain issued while the first command is still in flight
        send_cmd(3'd0, 5'd3, 5'd1, 5'd2, 1'b1, a0);
        send_cmd(3'd0, 5'd5, 5'd3, 5'd3, 1'b1, a1);
        check("raw_spacing", 64'(a1 - a0), 64'd4);
        wait_idle();
        rf_read(5'd5, rd_val);
        check("rd_R5_raw", rd_val, 64'd600);

        nd = n_done;
        send_cmd(3'd7, 5'd1, 5'd2, 5'd2, 1'b1, a0);
        wait_idle();
        check("nop_done", 64'(n_done - nd), 64'd1);
        rf_read(5'd1, rd_val);
        check("nop_R1", rd_val, 64'd100);

        // Reset while the ADD to R6 sits in CAPT
        send_cmd(3'd0, 5'd6, 5'd1, 5'd2, 1'b0, a0);
        @(negedge clk);
        @(negedge clk);
        check("capt_state", 64'(dbg_state), 64'(ST_CAPT));
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 64'(cmd_if.cmd_ready), 64'd0);
        check("mid_rst_enables", 64'({r1, r2, w1}), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        check("mid_rst_result", cmd_if.result, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(cmd_if.cmd_ready), 64'd1);
        check("post_rst_out", 64'({w1, cmd_if.done, w1p}), 64'd0);
        check("post_rst_ip1", ip1, 64'd0);
        wait_idle();
        rf_read(5'd6, rd_val);
        check("rd_R6_kept", rd_val, model[6]);

        for (int i = 0; i < 24; i++) begin
            send_cmd(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), 1'b1, a0);
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        wait_idle();
        for (int i = 0; i < 32; i++) begin
            rf_read(5'(i), rd_val);
            check($sformatf("final_R%0d", i), rd_val, model[i]);
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(n_done), 64'(n_done_exp));
        check("accept_count", 64'(n_acc), 64'(n_acc_exp));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_alu_sequencer.md
# rf_alu_sequencer

Command-driven initiator for the 64-bit, 32-entry multi-port register file: accepts one register-to-register ALU command per handshake, issues the two operand reads on read ports 1/2, captures the registered read data, computes the result and writes it back through write port 1. Sits between the instruction source (decoder or testbench) and the register file; read ports 3/4 and write port 2 stay free for other agents and are tied low at the top level.

## Interface
- DATA_W, 64, datapath width (must match register file)
- ADDR_W, 5, register index width
- clk  in  1  rising-edge clock, shared with the register file
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  opcode (see Operation)
- cmd_rd, cmd_rs1, cmd_rs2  in  ADDR_W each  destination / source indices
- r1, r2  out  1 each  register-file read enables
- r1p, r2p  out  ADDR_W each  read addresses
- op1, op2  in  DATA_W each  registered read data from the register file
- w1  out  1  register-file write enable
- w1p  out  ADDR_W  write address
- ip1  out  DATA_W  write data
- done  out  1  one-cycle pulse: command retired
- result  out  DATA_W  last computed result, held until the next EXEC

## Operation
- FSM states: IDLE, READ, CAPT, WRITE.
- IDLE: cmd_ready=1; on cmd_valid&&cmd_ready latch op/rd/rs1/rs2 -> READ. Otherwise stay.
- READ: r1=r2=1, r1p=rs1, r2p=rs2, w1=0 -> CAPT. The register file loads op1/op2 at this edge.
- CAPT: all enables 0; sample op1/op2, compute, register into result -> WRITE.
- WRITE: w1=1, w1p=rd, ip1=result (w1=0 for NOP) -> IDLE; done asserted in the following IDLE cycle.
- Reads and writes never overlap: the register file gives write priority and would silently drop a read issued with w1 high.
- Opcodes: 0 ADD, 1 SUB (rs1-rs2), 2 AND, 3 OR, 4 XOR, 5 MOV (rs1), 6 SLL (rs1 << rs2[5:0]), 7 NOP (no write, still retires).
- Arithmetic modulo 2^DATA_W; carries/borrows discarded; no flags.
- rd=0 is an ordinary register (written like any other).
- rs1==rs2 legal; rd==rs1/rs2 legal (write happens after read).
- cmd_valid while not IDLE: ignored (cmd_ready=0), command must be held by source.

## Timing
- Accept at edge E0; READ cycle 1, CAPT cycle 2, WRITE cycle 3 (write committed at end of cycle 3); done high cycle 4.
- Throughput: one command per 4 cycles; done and a new accept may occur in the same IDLE cycle.
- Back-to-back RAW dependency needs no stall: next READ is at cycle 5 at earliest, after write commit.
- cmd_ready is a decode of state (IDLE), not registered separately.
- Reset values (cycle after reset sampled high): state IDLE, r1=r2=w1=0, r1p=r2p=w1p=0, ip1=0, result=0, done=0; cmd_ready=0 while reset is high, 1 the cycle after release.
- Reset mid-command (any state): command dropped, no write issued, no done pulse; reset during WRITE prevents the write if sampled on that edge.

## Structure
- Package rf_seq_pkg: opcode enum (OP_ADD..OP_NOP), state enum, DATA_W/ADDR_W defaults.
- Sub-module rf_seq_alu: combinational (op, a, b) -> y; FSM and registers in rf_alu_sequencer.
- Bench instantiates this block with the existing register file to close the loop.

## Test plan
- Preload R1=100, R2=200 (via write port 2); cmd ADD rd=3 rs1=1 rs2=2 -> r1/r2 high cycle 1, w1=1 w1p=3 ip1=300 cycle 3, done cycle 4; later read of R3 = 300.
- SUB rd=4 rs1=1 rs2=2 -> ip1=0xFFFF_FFFF_FFFF_FF9C; SLL R1 by 4 -> 1600; XOR R1,R1 -> 0.
- RAW chain: ADD R3=R1+R2, then ADD R5=R3+R3 issued on done cycle -> R5=600, accepts spaced exactly 4 cycles.
- cmd_valid held high during busy -> only one accept per IDLE, cmd_ready low cycles 1-3; NOP rd=1 -> no w1 pulse, R1 unchanged, done still pulses.
- Assert reset in CAPT of an ADD rd=6 -> no w1 pulse, no done, R6 unchanged, outputs at reset values, cmd_ready=1 after release.
- Property: r1|r2 and w1 never high in the same cycle across random command streams.
